// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed, little-endian data memory for the MEM stage.
// NB byte lanes of DEPTH/NB rows each. Byte/half/word accesses with per-lane
// enables, sign/zero extension on loads, range checking with an error flag,
// and automatic two-cycle splitting of accesses that cross a row boundary.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepting requests; non-split accesses complete at the accept edge
// SPLIT | second half of a row-crossing access pending; inputs ignored
module dmem_ctrl #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 1024,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int NB   = DATA_W / 8;
  localparam int LB   = $clog2(NB);
  localparam int ROWS = DEPTH / NB;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t state, state_nxt;

  // request fields registered at accept, replayed during SPLIT
  logic              r_we, r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic [DATA_W-1:0] r_wdata;

  // the access being worked on this cycle (live inputs in IDLE, held ones in SPLIT)
  logic              in_split;
  logic              c_we, c_signed;
  logic [ADDR_W-1:0] c_addr;
  logic [1:0]        c_size;
  logic [DATA_W-1:0] c_wdata;
  logic [LB-1:0]     c_lane;
  logic [RW-1:0]     c_row;
  logic [3:0]        c_nbytes;
  logic [ADDR_W:0]   c_end;
  logic              c_err, c_split;

  logic accept, do_op, done;

  logic [NB-1:0] lane_hit;
  logic [LB-1:0] koff  [NB];
  logic [RW-1:0] row_l [NB];
  logic [7:0]    rd_b  [NB];
  logic [7:0]    asm_b [NB];
  logic [7:0]    hold  [NB];
  logic          sign_bit;
  logic [DATA_W-1:0] ld_data;

  // select the active access and derive its geometry, range error and split need
  always_comb begin
    in_split = (state == SPLIT);
    c_we     = in_split ? r_we     : req_we;
    c_signed = in_split ? r_signed : req_signed;
    c_addr   = in_split ? r_addr   : req_addr;
    c_size   = in_split ? r_size   : req_size;
    c_wdata  = in_split ? r_wdata  : req_wdata;
    c_lane   = c_addr[LB-1:0];
    c_row    = RW'(c_addr >> LB);
    c_nbytes = 4'b0001 << c_size;
    // one extra bit so an access near the top of the address space cannot wrap
    c_end    = {1'b0, c_addr} + (ADDR_W + 1)'(c_nbytes);
    c_err    = (c_nbytes > 4'(NB)) || (c_end > DEPTH_L);
    c_split  = !c_err && ((5'(c_lane) + 5'(c_nbytes)) > 5'(NB));
  end

  assign accept = req_valid && req_ready;
  assign do_op  = accept || in_split;
  assign done   = (accept && !c_split) || in_split;

  // per-lane decode: byte offset within the access, target row, storage
  for (genvar L = 0; L < NB; L++) begin : g_lane
    logic [7:0] mem [ROWS];
    logic       first, in_acc, wr_en;
    logic [7:0] wr_byte;

    // lanes at or above the start lane belong to row r, the rest wrap to r+1
    assign koff[L]     = LB'(L) - c_lane;
    assign first       = (LB'(L) >= c_lane);
    assign in_acc      = (4'(koff[L]) < c_nbytes);
    assign lane_hit[L] = in_acc && (in_split ? !first : first);
    assign row_l[L]    = first ? c_row : c_row + RW'(1);
    assign wr_en       = do_op && lane_hit[L] && c_we && !c_err;
    assign wr_byte     = c_wdata[{koff[L], 3'b000} +: 8];
    assign rd_b[L]     = mem[row_l[L]];

    if (CLEAR_ON_RST != 0) begin : g_clr
      // lane storage, zeroed by reset
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < ROWS; i++) mem[i] <= 8'h00;
        end else if (wr_en) begin
          mem[row_l[L]] <= wr_byte;
        end
      end
    end else begin : g_keep
      // lane storage, contents survive reset
      always_ff @(posedge clk) begin
        if (wr_en) mem[row_l[L]] <= wr_byte;
      end
    end
  end

  // gather load bytes in access order; bytes not read this cycle come from hold
  always_comb begin
    for (int k = 0; k < NB; k++) begin
      logic [LB-1:0] idx;
      idx      = c_lane + LB'(k);
      asm_b[k] = lane_hit[idx] ? rd_b[idx] : hold[k];
    end
  end

  // extend the assembled bytes to the full data width
  always_comb begin
    sign_bit = 1'b0;
    ld_data  = '0;
    for (int k = 0; k < NB; k++) begin
      if (4'(k) == c_nbytes - 4'd1) sign_bit = asm_b[k][7];
    end
    for (int k = 0; k < NB; k++) begin
      if (4'(k) < c_nbytes) ld_data[8*k +: 8] = asm_b[k];
      else                  ld_data[8*k +: 8] = c_signed ? {8{sign_bit}} : 8'h00;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: only a row-crossing accepted access enters SPLIT
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && c_split) state_nxt = SPLIT;
      SPLIT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  // capture the request so SPLIT can finish it regardless of new inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_size   <= '0;
      r_wdata  <= '0;
    end else if (accept) begin
      r_we     <= req_we;
      r_signed <= req_signed;
      r_addr   <= req_addr;
      r_size   <= req_size;
      r_wdata  <= req_wdata;
    end
  end

  // keep first-half load bytes of a split access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NB; k++) hold[k] <= 8'h00;
    end else if (accept && c_split) begin
      hold <= asm_b;
    end
  end

  // registered response; data and error hold between pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= done;
      if (done) begin
        resp_err   <= c_err;
        resp_rdata <= (c_err || c_we) ? '0 : ld_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl (DATA_W=16, DEPTH=256, clear on reset).
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [15:0] req_addr, req_wdata, resp_rdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err, busy;

  int total  = 0;
  int passed = 0;

  dmem_ctrl #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .CLEAR_ON_RST(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // present a request (called at a negedge)
  task automatic drive(input logic we, input logic [15:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [15:0] wd);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_signed = sgn; req_wdata = wd;
  endtask

  // one-cycle request; returns at the negedge after the accept edge
  task automatic do_req(input logic we, input logic [15:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [15:0] wd);
    drive(we, addr, size, sgn, wd);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", req_ready); else passed++;
    total++; if (resp_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", resp_valid); else passed++;
    total++; if (resp_rdata !== 16'h0) $display("FAIL rst_rdata got %h exp 0000", resp_rdata); else passed++;
    total++; if (resp_err !== 1'b0) $display("FAIL rst_err got %b exp 0", resp_err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else passed++;
  endtask

  task automatic test_aligned();
    drive(1'b1, 16'h0010, 2'd1, 1'b0, 16'hBEEF);
    total++; if (req_ready !== 1'b1) $display("FAIL al_ready got %b exp 1", req_ready); else passed++;
    @(negedge clk); req_valid = 1'b0;
    total++; if (resp_valid !== 1'b1) $display("FAIL al_st_valid got %b exp 1", resp_valid); else passed++;
    total++; if (resp_rdata !== 16'h0 || resp_err !== 1'b0)
      $display("FAIL al_st_resp got %h/%b exp 0000/0", resp_rdata, resp_err); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL al_ready_resp got %b exp 1", req_ready); else passed++;
    do_req(1'b0, 16'h0010, 2'd1, 1'b0, 16'h0);
    total++; if (resp_valid !== 1'b1 || resp_rdata !== 16'hBEEF)
      $display("FAIL al_ld got %b/%h exp 1/beef", resp_valid, resp_rdata); else passed++;
    @(negedge clk);
    total++; if (resp_valid !== 1'b0) $display("FAIL al_pulse got %b exp 0", resp_valid); else passed++;
    total++; if (resp_rdata !== 16'hBEEF) $display("FAIL al_hold got %h exp beef", resp_rdata); else passed++;
  endtask

  task automatic test_byte();
    do_req(1'b1, 16'h0021, 2'd0, 1'b0, 16'h5580);
    do_req(1'b0, 16'h0021, 2'd0, 1'b1, 16'h0);
    total++; if (resp_rdata !== 16'hFF80) $display("FAIL byte_signed got %h exp ff80", resp_rdata); else passed++;
    do_req(1'b0, 16'h0021, 2'd0, 1'b0, 16'h0);
    total++; if (resp_rdata !== 16'h0080) $display("FAIL byte_unsigned got %h exp 0080", resp_rdata); else passed++;
    do_req(1'b0, 16'h0020, 2'd0, 1'b1, 16'h0);
    total++; if (resp_rdata !== 16'h0000) $display("FAIL byte_neighbour got %h exp 0000", resp_rdata); else passed++;
  endtask

  task automatic test_misaligned();
    do_req(1'b1, 16'h0011, 2'd1, 1'b0, 16'h1234);
    total++; if (busy !== 1'b1 || req_ready !== 1'b0)
      $display("FAIL mis_busy got %b/%b exp 1/0", busy, req_ready); else passed++;
    total++; if (resp_valid !== 1'b0) $display("FAIL mis_early got %b exp 0", resp_valid); else passed++;
    @(negedge clk);
    total++; if (resp_valid !== 1'b1 || busy !== 1'b0)
      $display("FAIL mis_st_done got %b/%b exp 1/0", resp_valid, busy); else passed++;
    do_req(1'b0, 16'h0011, 2'd0, 1'b0, 16'h0);
    total++; if (resp_rdata !== 16'h0034) $display("FAIL mis_b11 got %h exp 0034", resp_rdata); else passed++;
    do_req(1'b0, 16'h0012, 2'd0, 1'b0, 16'h0);
    total++; if (resp_rdata !== 16'h0012) $display("FAIL mis_b12 got %h exp 0012", resp_rdata); else passed++;
    do_req(1'b0, 16'h0011, 2'd1, 1'b0, 16'h0);
    total++; if (resp_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL mis_ld_wait got %b/%b exp 0/1", resp_valid, busy); else passed++;
    // inputs during SPLIT must be ignored
    drive(1'b1, 16'h0030, 2'd1, 1'b0, 16'hDEAD);
    @(negedge clk); req_valid = 1'b0;
    total++; if (resp_valid !== 1'b1 || resp_rdata !== 16'h1234)
      $display("FAIL mis_ld got %b/%h exp 1/1234", resp_valid, resp_rdata); else passed++;
    do_req(1'b0, 16'h0010, 2'd1, 1'b1, 16'h0);
    total++; if (resp_rdata !== 16'h34EF) $display("FAIL mis_overlap got %h exp 34ef", resp_rdata); else passed++;
    do_req(1'b0, 16'h0030, 2'd1, 1'b0, 16'h0);
    total++; if (resp_rdata !== 16'h0000) $display("FAIL mis_ignored got %h exp 0000", resp_rdata); else passed++;
  endtask

  task automatic test_errors();
    do_req(1'b0, 16'h00FF, 2'd1, 1'b0, 16'h0);
    total++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 16'h0)
      $display("FAIL err_range got %b/%b/%h exp 1/1/0000", resp_valid, resp_err, resp_rdata); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL err_nosplit got %b exp 0", busy); else passed++;
    do_req(1'b1, 16'h00FF, 2'd0, 1'b0, 16'h00A5);
    total++; if (resp_err !== 1'b0) $display("FAIL err_top_st got %b exp 0", resp_err); else passed++;
    do_req(1'b0, 16'h00FF, 2'd0, 1'b0, 16'h0);
    total++; if (resp_rdata !== 16'h00A5 || resp_err !== 1'b0)
      $display("FAIL err_top_ld got %h/%b exp 00a5/0", resp_rdata, resp_err); else passed++;
    do_req(1'b1, 16'h0040, 2'd2, 1'b0, 16'hFFFF);
    total++; if (resp_err !== 1'b1) $display("FAIL err_size got %b exp 1", resp_err); else passed++;
    do_req(1'b0, 16'h0040, 2'd1, 1'b0, 16'h0);
    total++; if (resp_rdata !== 16'h0000 || resp_err !== 1'b0)
      $display("FAIL err_nowrite got %h/%b exp 0000/0", resp_rdata, resp_err); else passed++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 16'h0040, 2'd1, 1'b0, 16'hCAFE);
    @(negedge clk);
    total++; if (resp_valid !== 1'b1 || req_ready !== 1'b1)
      $display("FAIL b2b_st got %b/%b exp 1/1", resp_valid, req_ready); else passed++;
    drive(1'b0, 16'h0040, 2'd1, 1'b0, 16'h0);
    @(negedge clk);
    total++; if (resp_valid !== 1'b1 || resp_rdata !== 16'hCAFE)
      $display("FAIL b2b_ld got %b/%h exp 1/cafe", resp_valid, resp_rdata); else passed++;
    drive(1'b0, 16'h0041, 2'd0, 1'b1, 16'h0);
    @(negedge clk); req_valid = 1'b0;
    total++; if (resp_valid !== 1'b1 || resp_rdata !== 16'hFFCA)
      $display("FAIL b2b_ld2 got %b/%h exp 1/ffca", resp_valid, resp_rdata); else passed++;
  endtask

  task automatic test_reset_split();
    drive(1'b1, 16'h0011, 2'd1, 1'b0, 16'h5678);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL rs_ready got %b/%b exp 1/0", req_ready, busy); else passed++;
    total++; if (resp_valid !== 1'b0 || resp_rdata !== 16'h0)
      $display("FAIL rs_resp got %b/%h exp 0/0000", resp_valid, resp_rdata); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (resp_valid !== 1'b0) $display("FAIL rs_noresp got %b exp 0", resp_valid); else passed++;
    do_req(1'b0, 16'h0011, 2'd1, 1'b0, 16'h0);
    @(negedge clk);
    total++; if (resp_valid !== 1'b1 || resp_rdata !== 16'h0000)
      $display("FAIL rs_cleared got %b/%h exp 1/0000", resp_valid, resp_rdata); else passed++;
    do_req(1'b0, 16'h0040, 2'd1, 1'b0, 16'h0);
    total++; if (resp_rdata !== 16'h0000) $display("FAIL rs_cleared40 got %h exp 0000", resp_rdata); else passed++;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_size = '0; req_signed = 1'b0; req_wdata = '0;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_aligned();
    test_byte();
    test_misaligned();
    test_errors();
    test_back_to_back();
    test_reset_split();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
